mem_port_sched: RTL and testbench

Per-cycle scheduler for the two-port data memory shared by the MA and MO pipeline stages.
- Generates the alternating port select: MO uses ow_mem_mp; MA uses the opposite port.
- Shares free memory slots with one external requester (debug/DMA) through a req/gnt handshake.
- External accesses follow the same two-phase model as the pipeline: the address phase sits in an MA slot, the data phase in the following MO slot on the same port.
- A wait counter forces a pipeline bubble so the external requester cannot starve.

---
 rtl/mem_port_sched_pkg.sv | 15 +
 rtl/mem_sched_starve_ctr.sv | 51 +++++
 rtl/mem_port_sched.sv | 140 ++++++++++++++
 tb/tb_mem_port_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_sched_pkg.sv
// Shared definitions for the MA/MO data-memory port scheduler: external-access
// state encoding and the access width constants.
package mem_port_sched_pkg;

  localparam int unsigned NarrowW  = 24;
  localparam int unsigned WideW    = 48;
  localparam int unsigned SizeAddr = WideW;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StResp = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mem_sched_starve_ctr.sv
// Saturating wait counter for a blocked external request, with a registered
// stall that forces an MA bubble so the requester eventually gets a free slot.
module mem_sched_starve_ctr
  import mem_port_sched_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pend_i,
  input  logic clr_i,
  output logic stall_o
);

  localparam logic [WAIT_W-1:0] CntMax = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              stall_q, stall_d;

  // Stall latches once the limit is hit and holds until the access is served,
  // covering an MA request that was already in flight when it rose.
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (clr_i) begin
      cnt_d   = '0;
      stall_d = 1'b0;
    end else if (pend_i) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + WAIT_W'(1);
      end
      if (cnt_d == CntMax) begin
        stall_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: rtl/mem_port_sched.sv
// Per-cycle port scheduler for the two-port data memory shared by MA and MO,
// slotting one external requester into idle MA/MO slot pairs.
module mem_port_sched
  import mem_port_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = SizeAddr,
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_ma_req,
  output logic              ow_mem_mp,
  output logic              ow_pipe_stall,
  input  logic              iw_ext_req,
  input  logic              iw_ext_we,
  input  logic              iw_ext_is48,
  input  logic [ADDR_W-1:0] iw_ext_addr,
  input  logic [ADDR_W-1:0] iw_ext_wdata,
  output logic              ow_ext_gnt,
  output logic              ow_ext_rvalid,
  output logic [ADDR_W-1:0] ow_ext_rdata,
  output logic              ow_ext_addr_en,
  output logic              ow_ext_port,
  output logic [ADDR_W-1:0] ow_ext_addr,
  output logic              ow_ext_we,
  output logic [ADDR_W-1:0] ow_ext_wdata,
  output logic              ow_ext_is48,
  input  logic [ADDR_W-1:0] iw_mem_rdata0,
  input  logic [ADDR_W-1:0] iw_mem_rdata1
);

  localparam logic [ADDR_W-1:0] NarrowMask = {{(ADDR_W - NarrowW){1'b0}}, {NarrowW{1'b1}}};

  sched_state_e      state_q, state_d;
  logic              mp_q;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              is48_q, is48_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] rdata_sel;
  logic              ctr_pend, ctr_clr;

  assign rdata_sel = port_q ? iw_mem_rdata1 : iw_mem_rdata0;

  always_comb begin
    state_d        = state_q;
    port_d         = port_q;
    we_d           = we_q;
    is48_d         = is48_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    ow_ext_gnt     = 1'b0;
    ow_ext_addr_en = 1'b0;
    ow_ext_port    = 1'b0;
    ow_ext_addr    = '0;
    ow_ext_we      = 1'b0;
    ow_ext_wdata   = '0;
    ow_ext_is48    = 1'b0;
    ow_ext_rvalid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An idle MA slot now means the MO slot on the same port is free next cycle.
        if (iw_ext_req && !iw_ma_req) begin
          ow_ext_gnt     = 1'b1;
          ow_ext_addr_en = 1'b1;
          ow_ext_port    = !mp_q;
          ow_ext_addr    = iw_ext_addr;
          port_d         = !mp_q;
          addr_d         = iw_ext_addr;
          we_d           = iw_ext_we;
          wdata_d        = iw_ext_wdata;
          is48_d         = iw_ext_is48;
          state_d        = StData;
        end
      end
      StData: begin
        ow_ext_port  = port_q;
        ow_ext_addr  = addr_q;
        ow_ext_we    = we_q;
        ow_ext_wdata = wdata_q;
        ow_ext_is48  = is48_q;
        if (we_q) begin
          state_d = StIdle;
        end else begin
          rdata_d = is48_q ? rdata_sel : (rdata_sel & NarrowMask);
          state_d = StResp;
        end
      end
      StResp: begin
        ow_ext_rvalid = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ctr_pend = (state_q == StIdle) && iw_ext_req && iw_ma_req;
  assign ctr_clr  = (state_q == StData) || ((state_q == StIdle) && !iw_ext_req);

  mem_sched_starve_ctr #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_starve_ctr (
    .clk_i   (iw_clk),
    .rst_ni  (iw_rst_n),
    .pend_i  (ctr_pend),
    .clr_i   (ctr_clr),
    .stall_o (ow_pipe_stall)
  );

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q <= StIdle;
      mp_q    <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      is48_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mp_q    <= !mp_q;
      port_q  <= port_d;
      we_q    <= we_d;
      is48_q  <= is48_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ow_mem_mp    = mp_q;
  assign ow_ext_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched: directed external loads/stores, starvation
// stall and mid-access reset, with a monitor checking every rvalid and write.
module tb_mem_port_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ma_req, ext_req, ext_we, ext_is48;
  logic [47:0] ext_addr, ext_wdata, rdata0, rdata1;
  logic        mem_mp, pipe_stall, gnt, rvalid, addr_en, o_port, o_we, o_is48;
  logic [47:0] o_rdata, o_addr, o_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] addr;
    logic [47:0] data;
    logic        is48;
  } wr_t;

  logic [47:0] rd_exp[$];
  wr_t         wr_exp[$];

  always #5 clk = !clk;

  mem_port_sched #(
    .ADDR_W   (48),
    .WAIT_MAX (8),
    .WAIT_W   (4)
  ) dut (
    .iw_clk         (clk),
    .iw_rst_n       (rst_n),
    .iw_ma_req      (ma_req),
    .ow_mem_mp      (mem_mp),
    .ow_pipe_stall  (pipe_stall),
    .iw_ext_req     (ext_req),
    .iw_ext_we      (ext_we),
    .iw_ext_is48    (ext_is48),
    .iw_ext_addr    (ext_addr),
    .iw_ext_wdata   (ext_wdata),
    .ow_ext_gnt     (gnt),
    .ow_ext_rvalid  (rvalid),
    .ow_ext_rdata   (o_rdata),
    .ow_ext_addr_en (addr_en),
    .ow_ext_port    (o_port),
    .ow_ext_addr    (o_addr),
    .ow_ext_we      (o_we),
    .ow_ext_wdata   (o_wdata),
    .ow_ext_is48    (o_is48),
    .iw_mem_rdata0  (rdata0),
    .iw_mem_rdata1  (rdata1)
  );

  task automatic check48(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every rvalid and every write must match a queued expectation.
  always @(negedge clk) begin
    if (rvalid) begin
      if (rd_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response", o_rdata);
      end else begin
        check48("rdata", o_rdata, rd_exp.pop_front());
      end
    end
    if (o_we) begin
      if (wr_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got we=1 addr=%h expected no write", o_addr);
      end else begin
        wr_t w;
        w = wr_exp.pop_front();
        check48("wr_addr", o_addr, w.addr);
        check48("wr_data", o_wdata, w.data);
        check1("wr_is48", o_is48, w.is48);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_mp(input logic want);
    int n = 0;
    while (mem_mp !== want && n < 4) begin
      cyc();
      n++;
    end
    check1("sync_mp", mem_mp, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ma_req    = 1'b0;
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_is48  = 1'b0;
    ext_addr  = '0;
    ext_wdata = '0;
    rdata0    = '0;
    rdata1    = '0;

    // 1: reset values and mp toggling
    repeat (2) cyc();
    #1;
    check1("rst_mp", mem_mp, 1'b0);
    check1("rst_gnt", gnt, 1'b0);
    check1("rst_rvalid", rvalid, 1'b0);
    check48("rst_rdata", o_rdata, 48'h0);
    check1("rst_stall", pipe_stall, 1'b0);
    check1("rst_addr_en", addr_en, 1'b0);
    check1("rst_port", o_port, 1'b0);
    check48("rst_addr", o_addr, 48'h0);
    check1("rst_we", o_we, 1'b0);
    check48("rst_wdata", o_wdata, 48'h0);
    rst_n = 1'b1;
    cyc(); #1 check1("mp_seq1", mem_mp, 1'b1);
    cyc(); #1 check1("mp_seq2", mem_mp, 1'b0);
    cyc(); #1 check1("mp_seq3", mem_mp, 1'b1);
    check1("idle_stall", pipe_stall, 1'b0);

    // 2: 48-bit load on port 1
    cyc();
    sync_mp(1'b0);
    ext_req = 1'b1; ext_we = 1'b0; ext_is48 = 1'b1; ext_addr = 48'h10;
    rdata1 = 48'h123456789ABC; rdata0 = 48'hDEAD00BEEF11;
    #1;
    check1("ld_gnt", gnt, 1'b1);
    check1("ld_addr_en", addr_en, 1'b1);
    check1("ld_port", o_port, 1'b1);
    check48("ld_addr", o_addr, 48'h10);
    rd_exp.push_back(48'h123456789ABC);
    cyc();
    ext_req = 1'b0;
    #1;
    check1("ld_data_mp", mem_mp, 1'b1);
    check1("ld_data_port", o_port, 1'b1);
    check1("ld_data_gnt", gnt, 1'b0);
    check1("ld_data_we", o_we, 1'b0);
    check1("ld_data_rvalid", rvalid, 1'b0);
    cyc(); #1 check1("ld_rvalid", rvalid, 1'b1);
    cyc(); #1 check1("ld_rvalid_end", rvalid, 1'b0);

    // 3: 24-bit store on port 0
    sync_mp(1'b1);
    ext_req = 1'b1; ext_we = 1'b1; ext_is48 = 1'b0; ext_addr = 48'h30;
    ext_wdata = 48'hFFFFFF00AA55;
    #1;
    check1("st_gnt", gnt, 1'b1);
    check1("st_port", o_port, 1'b0);
    check1("st_we_addr_phase", o_we, 1'b0);
    wr_exp.push_back('{addr: 48'h30, data: 48'hFFFFFF00AA55, is48: 1'b0});
    cyc();
    ext_req = 1'b0; ext_we = 1'b0;
    #1;
    check1("st_we", o_we, 1'b1);
    check1("st_data_port", o_port, 1'b0);
    cyc(); #1;
    check1("st_we_end", o_we, 1'b0);
    check1("st_no_rvalid", rvalid, 1'b0);

    // 4: starvation, forced stall, then grant
    ma_req = 1'b1; ext_req = 1'b1; ext_we = 1'b1; ext_is48 = 1'b1;
    ext_addr = 48'h20; ext_wdata = 48'h0123456789AB;
    for (int i = 0; i < 8; i++) begin
      #1;
      check1("starve_gnt", gnt, 1'b0);
      check1("starve_stall_low", pipe_stall, 1'b0);
      cyc();
    end
    #1;
    check1("starve_stall", pipe_stall, 1'b1);
    check1("starve_gnt_inflight", gnt, 1'b0);
    wr_exp.push_back('{addr: 48'h20, data: 48'h0123456789AB, is48: 1'b1});
    cyc();
    ma_req = 1'b0;
    #1;
    check1("starve_grant", gnt, 1'b1);
    check1("starve_stall_hold", pipe_stall, 1'b1);
    cyc();
    ext_req = 1'b0; ext_we = 1'b0;
    #1;
    check1("starve_data_we", o_we, 1'b1);
    check1("starve_stall_data", pipe_stall, 1'b1);
    cyc(); #1;
    check1("starve_stall_clr", pipe_stall, 1'b0);

    // 5: 24-bit load on port 0, upper bits masked
    sync_mp(1'b1);
    ext_req = 1'b1; ext_we = 1'b0; ext_is48 = 1'b0; ext_addr = 48'h40;
    rdata0 = 48'hABCDEF123456; rdata1 = 48'h111111111111;
    #1;
    check1("ld24_gnt", gnt, 1'b1);
    check1("ld24_port", o_port, 1'b0);
    rd_exp.push_back(48'h000000123456);
    cyc();
    ext_req = 1'b0;
    cyc(); #1 check1("ld24_rvalid", rvalid, 1'b1);
    cyc(); #1 check1("ld24_rvalid_end", rvalid, 1'b0);

    // 6: reset during the data phase abandons the load
    sync_mp(1'b0);
    ext_req = 1'b1; ext_we = 1'b0; ext_is48 = 1'b1; ext_addr = 48'h50;
    rdata0 = 48'h555555555555; rdata1 = 48'hAAAAAAAAAAAA;
    #1;
    check1("rst_ld_gnt", gnt, 1'b1);
    cyc();
    ext_req = 1'b0;
    rst_n = 1'b0;
    cyc(); #1;
    check1("midrst_mp", mem_mp, 1'b0);
    check1("midrst_rvalid", rvalid, 1'b0);
    check48("midrst_rdata", o_rdata, 48'h0);
    check1("midrst_stall", pipe_stall, 1'b0);
    check1("midrst_port", o_port, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check1("post_rst_rvalid", rvalid, 1'b0);
      check1("post_rst_we", o_we, 1'b0);
    end

    check48("rd_queue_drained", 48'(rd_exp.size()), 48'h0);
    check48("wr_queue_drained", 48'(wr_exp.size()), 48'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
